// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared types for the stereo depth pipeline's winner-take-all stage.
//
// Optional feature macro: WTA_UNIQUENESS_EN (adds the second-best sum to
// wta_entry_t).
//
// The ws_t / disp_t / wta_entry_t types describe the default build
// (14-bit window sums, 64 disparities). wta_disparity_select re-derives
// equivalent local types from its own parameters so that other lane counts
// and disparity ranges keep matching widths.
// -----------------------------------------------------------------------------
package stereo_pkg;

  localparam int WS_W_DEF   = 14;
  localparam int DISP_W_DEF = 6;

  typedef logic [WS_W_DEF-1:0]   ws_t;
  typedef logic [DISP_W_DEF-1:0] disp_t;

  // Disparity code reported for pixels that fail the uniqueness test.
  localparam disp_t DISP_INVALID = '1;

  typedef struct packed {
    ws_t   sum;
    disp_t disp;
`ifdef WTA_UNIQUENESS_EN
    ws_t   second;
`endif
  } wta_entry_t;

  // Line-level control state, also exported on the debug port.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wta_state_e;

  // Width of a counter/index able to hold 0..n-1 (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wta_disparity_select_if.sv
// -----------------------------------------------------------------------------
// wta_disparity_select_if
// Beat/result bundle between the SAD pipelines, the WTA selector and the
// output FIFO.
//
// Handshake: a beat is transferred in every cycle where in_valid is high;
// there is no ready (the source is camera-paced and the selector always
// accepts). out_valid is a one-cycle pulse per pixel result with no
// backpressure. line_start is a pulse that restarts the pass/pixel counters
// and may coincide with the first beat of the new line.
//
// Signals:
//   line_start, in_valid, in_ws          source -> selector
//   out_valid, out_disparity,
//   out_window_sum, busy, line_error     selector -> sink
//   dbg_state                            selector control state (debug)
// -----------------------------------------------------------------------------
interface wta_disparity_select_if
  import stereo_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WS_W   = 14,
  parameter int DISP_W = 6
) ();

  logic                    line_start;
  logic                    in_valid;
  logic [LANES*WS_W-1:0]   in_ws;
  logic                    out_valid;
  logic [DISP_W-1:0]       out_disparity;
  logic [WS_W-1:0]         out_window_sum;
  logic                    busy;
  logic                    line_error;
  wta_state_e              dbg_state;

  modport master (
    output line_start, in_valid, in_ws,
    input  out_valid, out_disparity, out_window_sum, busy, line_error,
           dbg_state
  );

  modport slave (
    input  line_start, in_valid, in_ws,
    output out_valid, out_disparity, out_window_sum, busy, line_error,
           dbg_state
  );

endinterface

// File: rtl/lane_min_tree.sv
// -----------------------------------------------------------------------------
// lane_min_tree
// Combinational LANES-input minimum / argmin over packed window sums.
// Ties keep the lower lane index (strict less-than).
//
// Optional feature macro: WTA_UNIQUENESS_EN (adds second_sum_o, the smallest
// sum among the lanes other than the winner; all ones when LANES==1).
//
// Ports:
//   sums_i        LANES*WS_W  lane k at [k*WS_W +: WS_W]
//   min_sum_o     WS_W        smallest sum
//   min_idx_o     IDX_W       lane index of the smallest sum
//   second_sum_o  WS_W        second smallest sum (macro only)
// -----------------------------------------------------------------------------
module lane_min_tree #(
  parameter int LANES = 4,
  parameter int WS_W  = 14,
  parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*WS_W-1:0] sums_i,
  output logic [WS_W-1:0]       min_sum_o,
`ifdef WTA_UNIQUENESS_EN
  output logic [WS_W-1:0]       second_sum_o,
`endif
  output logic [IDX_W-1:0]      min_idx_o
);

  logic [WS_W-1:0]  min_v;
  logic [IDX_W-1:0] min_i;
  logic [WS_W-1:0]  lane_v;
`ifdef WTA_UNIQUENESS_EN
  logic [WS_W-1:0]  sec_v;
`endif

  always_comb begin
    min_v  = sums_i[0 +: WS_W];
    min_i  = '0;
    lane_v = '0;
`ifdef WTA_UNIQUENESS_EN
    sec_v  = '1;
`endif
    for (int k = 1; k < LANES; k++) begin
      lane_v = sums_i[k*WS_W +: WS_W];
      if (lane_v < min_v) begin
`ifdef WTA_UNIQUENESS_EN
        sec_v = min_v;
`endif
        min_v = lane_v;
        min_i = IDX_W'(k);
      end
`ifdef WTA_UNIQUENESS_EN
      // A tie with the winner still counts as a competing second best.
      else if (lane_v < sec_v) begin
        sec_v = lane_v;
      end
`endif
    end
  end

  assign min_sum_o = min_v;
  assign min_idx_o = min_i;
`ifdef WTA_UNIQUENESS_EN
  assign second_sum_o = sec_v;
`endif

endmodule

// File: rtl/wta_disparity_select.sv
// -----------------------------------------------------------------------------
// wta_disparity_select
// Winner-take-all disparity selector. Window sums from LANES parallel SAD
// pipelines arrive over PASSES passes of one image line; a per-pixel running
// best is kept in a LINE_W-entry line buffer and the final disparity and
// window sum are emitted during the last pass, one pulse per pixel in order.
//
// Optional feature macro: WTA_UNIQUENESS_EN. When defined, the second-best
// sum is tracked too and pixels whose (second - best) < UNIQ_MARGIN report
// the all-ones invalid disparity code. Latency is the same either way.
//
// Ports:
//   clock   pipeline clock
//   reset   asynchronous, active high
//   bus     wta_disparity_select_if.slave (beats in, results/status out)
//
// Pipeline (edge E0 accepts the beat):
//   E0  capture beat with its pixel/pass coordinates
//   E1  stage 1: lane minimum, local disparity = pass*LANES + lane
//   E2  stage 2: line-buffer read of the stored best for that pixel
//   E3  merge; write back (earlier passes) or output register (final pass)
// -----------------------------------------------------------------------------
module wta_disparity_select
  import stereo_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PASSES      = 16,
  parameter int LINE_W      = 640,
  parameter int WS_W        = 14,
  parameter int DISP_W      = $clog2(LANES*PASSES),
  parameter int UNIQ_MARGIN = 8
) (
  input logic                   clock,
  input logic                   reset,
  wta_disparity_select_if.slave bus
);

  localparam int X_W   = idx_width(LINE_W);
  localparam int P_W   = idx_width(PASSES);
  localparam int IDX_W = idx_width(LANES);

  // The line buffer is read once and written once per pixel per pass; the
  // same address comes round again only LINE_W beats later.
  if (LANES < 1 || PASSES < 1 || LINE_W < 4 || UNIQ_MARGIN < 0) begin : g_bad_cfg
    $error("wta_disparity_select: unsupported parameter set");
  end

  typedef logic [WS_W-1:0]   sum_t;
  typedef logic [DISP_W-1:0] dsp_t;

  typedef struct packed {
    sum_t sum;
    dsp_t disp;
`ifdef WTA_UNIQUENESS_EN
    sum_t second;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------
  // Line control: pixel/pass counters and IDLE/RUN state
  // ---------------------------------------------------------------------------
  wta_state_e       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [P_W-1:0]   pass_q, pass_d;
  logic             err_q, err_d;
  logic [X_W-1:0]   beat_x;
  logic [P_W-1:0]   beat_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    pass_d    = pass_q;
    err_d     = err_q;
    beat_x    = x_q;
    beat_pass = pass_q;

    // line_start restarts the counters; a beat in the same cycle is
    // pixel 0 of pass 0 of the new line.
    if (bus.line_start) begin
      if (state_q == ST_RUN) err_d = 1'b1;
      beat_x    = '0;
      beat_pass = '0;
      x_d       = '0;
      pass_d    = '0;
      if (!bus.in_valid) state_d = ST_IDLE;
    end

    if (bus.in_valid) begin
      state_d = ST_RUN;
      if (beat_x == X_W'(LINE_W-1)) begin
        x_d = '0;
        if (beat_pass == P_W'(PASSES-1)) begin
          pass_d  = '0;
          state_d = ST_IDLE;
        end else begin
          pass_d = beat_pass + P_W'(1);
        end
      end else begin
        x_d    = beat_x + X_W'(1);
        pass_d = beat_pass;
      end
    end
  end

  assign bus.busy       = (state_q == ST_RUN);
  assign bus.line_error = err_q;
  assign bus.dbg_state  = state_q;

  // ---------------------------------------------------------------------------
  // E0: beat capture
  // ---------------------------------------------------------------------------
  logic                  a_valid_q;
  logic [LANES*WS_W-1:0] a_ws_q;
  logic [X_W-1:0]        a_x_q;
  logic [P_W-1:0]        a_pass_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_ws_q    <= '0;
      a_x_q     <= '0;
      a_pass_q  <= '0;
    end else begin
      a_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_ws_q   <= bus.in_ws;
        a_x_q    <= beat_x;
        a_pass_q <= beat_pass;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // E1: stage 1, lane reduction
  // ---------------------------------------------------------------------------
  sum_t             lane_min;
  logic [IDX_W-1:0] lane_idx;
  entry_t           s1_cand;
`ifdef WTA_UNIQUENESS_EN
  sum_t             lane_second;
`endif

  lane_min_tree #(
    .LANES (LANES),
    .WS_W  (WS_W),
    .IDX_W (IDX_W)
  ) u_lane_min_tree (
    .sums_i       (a_ws_q),
    .min_sum_o    (lane_min),
`ifdef WTA_UNIQUENESS_EN
    .second_sum_o (lane_second),
`endif
    .min_idx_o    (lane_idx)
  );

  always_comb begin
    s1_cand      = '0;
    s1_cand.sum  = lane_min;
    s1_cand.disp = DISP_W'(int'(a_pass_q) * LANES + int'(lane_idx));
`ifdef WTA_UNIQUENESS_EN
    s1_cand.second = lane_second;
`endif
  end

  logic           s1_valid_q, s1_first_q, s1_last_q;
  entry_t         s1_entry_q;
  logic [X_W-1:0] s1_x_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_entry_q <= '0;
      s1_x_q     <= '0;
    end else begin
      s1_valid_q <= a_valid_q;
      if (a_valid_q) begin
        s1_first_q <= (a_pass_q == '0);
        s1_last_q  <= (a_pass_q == P_W'(PASSES-1));
        s1_entry_q <= s1_cand;
        s1_x_q     <= a_x_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // E2: stage 2, line-buffer read (synchronous, so it maps onto block RAM)
  // ---------------------------------------------------------------------------
  logic           s2_valid_q, s2_first_q, s2_last_q;
  entry_t         s2_entry_q;
  logic [X_W-1:0] s2_x_q;
  entry_t         rd_q;
  entry_t         merged;
  logic           wr_en;
  entry_t         best_q [LINE_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_entry_q <= '0;
      s2_x_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_entry_q <= s1_entry_q;
        s2_x_q     <= s1_x_q;
      end
    end
  end

  // Contents need no reset: pass 0 overwrites every entry before it is used.
  always_ff @(posedge clock) begin
    rd_q <= best_q[s1_x_q];
    if (wr_en) best_q[s2_x_q] <= merged;
  end

  // ---------------------------------------------------------------------------
  // E3: merge, then write back or register the result
  // ---------------------------------------------------------------------------
  // Stored entries always come from earlier passes (lower disparities), so
  // on an equal sum the stored entry wins.
  always_comb begin
    merged = s2_entry_q;
    if (!s2_first_q) begin
      if (s2_entry_q.sum < rd_q.sum) begin
        merged = s2_entry_q;
`ifdef WTA_UNIQUENESS_EN
        merged.second = (rd_q.sum < s2_entry_q.second) ? rd_q.sum : s2_entry_q.second;
`endif
      end else begin
        merged = rd_q;
`ifdef WTA_UNIQUENESS_EN
        merged.second = (s2_entry_q.sum < rd_q.second) ? s2_entry_q.sum : rd_q.second;
`endif
      end
    end
  end

  assign wr_en = s2_valid_q && !s2_last_q;

  logic out_valid_q;
  dsp_t out_disp_q;
  sum_t out_sum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_disp_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      out_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        out_sum_q <= merged.sum;
`ifdef WTA_UNIQUENESS_EN
        // second >= best always holds, so the difference cannot wrap.
        if ((merged.second - merged.sum) < sum_t'(UNIQ_MARGIN))
          out_disp_q <= '1;
        else
          out_disp_q <= merged.disp;
`else
        out_disp_q <= merged.disp;
`endif
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_disparity  = out_disp_q;
  assign bus.out_window_sum = out_sum_q;

endmodule
